// File: rtl/pingpong_drain_arbiter.sv
// pingpong_drain_arbiter
//   Drains completed frames from the read bank of a ping-pong sample buffer
//   and hands each frame, atomically, to one of two consumers chosen
//   round-robin. Frames lost to a buffer swap (overrun) are flagged and
//   counted.
//
// Optional feature: define DRAIN_TIMEOUT_EN to enable a stall watchdog that
//   aborts a frame after TIMEOUT_CYCLES consecutive cycles without an
//   accepted beat.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   buf_ready_i       pulse: a new frame has swapped into the read bank
//   buf_data_i/valid  buffer read port; buf_rd_ready_o is its ready
//   req_i[1:0]        per-consumer frame request (level)
//   gnt_o[1:0]        one-hot grant, held for the whole frame
//   m_data_o/m_valid_o/m_last_o, m_ready_i[1:0]  stream to the granted consumer
//   busy_o            high while streaming
//   frame_drop_o      pulse per dropped or aborted frame
//   frame_count_o     completed frames (wraps)
//   drop_count_o      dropped/aborted frames (saturates at 255)
module pingpong_drain_arbiter #(
  parameter int unsigned WIDTH          = 36,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned ADDR_WIDTH     = $clog2(DEPTH),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             buf_ready_i,
  input  logic [WIDTH-1:0] buf_data_i,
  input  logic             buf_valid_i,
  output logic             buf_rd_ready_o,
  input  logic [1:0]       req_i,
  output logic [1:0]       gnt_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  output logic             m_last_o,
  input  logic [1:0]       m_ready_i,
  output logic             busy_o,
  output logic             frame_drop_o,
  output logic [15:0]      frame_count_o,
  output logic [7:0]       drop_count_o
);

  localparam int unsigned BW = ADDR_WIDTH + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE, S_ABORT} state_e;

  state_e        state_q;
  logic [1:0]    gnt_q;
  logic          pending_q;
  logic          rr_q;
  logic [BW-1:0] beat_q;
  logic [15:0]   frame_cnt_q;
  logic [7:0]    drop_cnt_q;
  logic          drop_q;

  logic          in_stream;
  logic          g_idx;
  logic          g_ready;
  logic          accept;
  logic          last_beat;
  logic          timeout;
  logic [7:0]    drop_cnt_inc;
  logic [1:0]    grant_d;

  always_comb begin
    in_stream    = (state_q == S_STREAM);
    g_idx        = gnt_q[1];
    g_ready      = m_ready_i[g_idx];
    accept       = in_stream && buf_valid_i && g_ready;
    last_beat    = (beat_q == LAST_BEAT);
    drop_cnt_inc = drop_cnt_q + 8'(drop_cnt_q != 8'hFF);
    grant_d      = '0;
    case (req_i)
      2'b01:   grant_d = 2'b01;
      2'b10:   grant_d = 2'b10;
      2'b11:   grant_d = rr_q ? 2'b10 : 2'b01;
      default: grant_d = 2'b00;
    endcase
  end

`ifdef DRAIN_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SW-1:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !in_stream || accept) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + SW'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign timeout = in_stream && !accept && (stall_q == SW'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent: the limit parameter is inert in this build.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // The stream path is purely combinational so the buffer sees the
  // consumer's ready with zero latency.
  assign m_data_o       = in_stream ? buf_data_i : '0;
  assign m_valid_o      = in_stream && buf_valid_i;
  assign m_last_o       = m_valid_o && last_beat;
  assign buf_rd_ready_o = in_stream && g_ready;
  assign busy_o         = in_stream;
  assign gnt_o          = gnt_q;
  assign frame_drop_o   = drop_q;
  assign frame_count_o  = frame_cnt_q;
  assign drop_count_o   = drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      pending_q   <= 1'b0;
      rr_q        <= 1'b0;
      beat_q      <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        S_STREAM: begin
          if (accept && last_beat) begin
            // A swap coinciding with the final beat does not corrupt it.
            state_q     <= S_DONE;
            gnt_q       <= '0;
            beat_q      <= '0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            rr_q        <= ~g_idx;
            if (buf_ready_i) pending_q <= 1'b1;
          end else if (buf_ready_i || timeout) begin
            // The swap reset the buffer's read pointer: the frame in flight
            // is lost, and the bank now holds a fresh frame to drain.
            state_q    <= S_ABORT;
            gnt_q      <= '0;
            beat_q     <= '0;
            rr_q       <= ~g_idx;
            drop_q     <= 1'b1;
            drop_cnt_q <= drop_cnt_inc;
            pending_q  <= 1'b1;
          end else if (accept) begin
            beat_q <= beat_q + BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (buf_ready_i) begin
            pending_q <= 1'b1;
            if (pending_q) begin
              drop_q     <= 1'b1;
              drop_cnt_q <= drop_cnt_inc;
            end
          end
          // Grant consumes the pending frame; overrides a same-cycle set.
          if (state_q == S_IDLE && pending_q && (req_i != 2'b00)) begin
            state_q   <= S_STREAM;
            gnt_q     <= grant_d;
            pending_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_drain_arbiter.sv
module tb_pingpong_drain_arbiter;

  localparam int unsigned W   = 36;
  localparam int unsigned D   = 8;
  localparam int unsigned TMO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         buf_ready;
  logic [W-1:0] buf_data;
  logic         buf_valid;
  logic         buf_rd_ready;
  logic [1:0]   req;
  logic [1:0]   gnt;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_last;
  logic [1:0]   m_ready;
  logic         busy;
  logic         frame_drop;
  logic [15:0]  frame_count;
  logic [7:0]   drop_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  pingpong_drain_arbiter #(
    .WIDTH(W),
    .DEPTH(D),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .buf_ready_i(buf_ready),
    .buf_data_i(buf_data),
    .buf_valid_i(buf_valid),
    .buf_rd_ready_o(buf_rd_ready),
    .req_i(req),
    .gnt_o(gnt),
    .m_data_o(m_data),
    .m_valid_o(m_valid),
    .m_last_o(m_last),
    .m_ready_i(m_ready),
    .busy_o(busy),
    .frame_drop_o(frame_drop),
    .frame_count_o(frame_count),
    .drop_count_o(drop_count)
  );

  // Reference model: a frame is either in flight (owner, beats delivered)
  // or not; a finished/aborted frame leaves one quiet cycle behind it.
  bit m_streaming, m_post, m_pending, m_drop;
  int m_who, m_rr, m_beats, m_stall, m_fcnt, m_dcnt;

  task automatic model_reset();
    m_streaming = 0; m_post = 0; m_pending = 0; m_drop = 0;
    m_who = 0; m_rr = 0; m_beats = 0; m_stall = 0; m_fcnt = 0; m_dcnt = 0;
  endtask

  task automatic count_drop();
    m_drop = 1;
    if (m_dcnt < 255) m_dcnt++;
  endtask

  task automatic model_edge();
    bit acc, tout, was_pending;
    m_drop = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_streaming) begin
      acc  = buf_valid && m_ready[m_who];
      tout = 0;
`ifdef DRAIN_TIMEOUT_EN
      if (acc) m_stall = 0;
      else begin
        m_stall++;
        tout = (m_stall >= TMO);
      end
`endif
      if (acc && m_beats == D - 1) begin
        m_streaming = 0;
        m_fcnt = (m_fcnt + 1) % 65536;
        m_rr = 1 - m_who;
        if (buf_ready) m_pending = 1;
      end else if (buf_ready || tout) begin
        m_streaming = 0;
        count_drop();
        m_rr = 1 - m_who;
        m_pending = 1;
      end else if (acc) begin
        m_beats++;
      end
      m_post = !m_streaming;
    end else begin
      was_pending = m_pending;
      if (buf_ready) begin
        if (m_pending) count_drop();
        m_pending = 1;
      end
      if (!m_post && was_pending && req != 2'b00) begin
        m_who = (req == 2'b11) ? m_rr : ((req == 2'b01) ? 0 : 1);
        m_streaming = 1; m_beats = 0; m_stall = 0; m_pending = 0;
      end
      m_post = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] eg;
    bit ev, erd;
    eg  = m_streaming ? ((m_who == 1) ? 2'b10 : 2'b01) : 2'b00;
    ev  = m_streaming && buf_valid;
    erd = m_streaming && m_ready[m_who];
    chk("gnt", 64'(gnt), 64'(eg));
    chk("busy", 64'(busy), 64'(m_streaming));
    chk("m_valid", 64'(m_valid), 64'(ev));
    chk("m_last", 64'(m_last), 64'(ev && m_beats == D - 1));
    chk("buf_rd_ready", 64'(buf_rd_ready), 64'(erd));
    chk("frame_drop", 64'(frame_drop), 64'(m_drop));
    chk("frame_count", 64'(frame_count), 64'(m_fcnt));
    chk("drop_count", 64'(drop_count), 64'(m_dcnt));
    if (m_streaming) chk("m_data", 64'(m_data), 64'(buf_data));
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse();
    buf_ready = 1'b1;
    tick();
    buf_ready = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    buf_data  = r[W-1:0];
    buf_ready = ($urandom_range(0, 39) == 0);
    buf_valid = ($urandom_range(0, 3) != 0);
    m_ready   = 2'($urandom_range(0, 3));
    req       = 2'($urandom_range(0, 3));
  endtask

  initial begin
    rst = 1'b1; buf_ready = 1'b0; buf_data = '0; buf_valid = 1'b0;
    req = 2'b00; m_ready = 2'b00;
    @(posedge clk);
    model_reset();
    #1;
    repeat (2) tick();
    rst = 1'b0;

    // Basic drain to consumer 0.
    req = 2'b01; buf_valid = 1'b1; m_ready = 2'b01;
    pulse();
    for (int i = 0; i < 14; i++) begin buf_data = W'(100 + i); tick(); end
    chk("basic_frames", 64'(frame_count), 64'd1);

    // Round-robin with both requesting.
    req = 2'b11; m_ready = 2'b11;
    for (int f = 0; f < 4; f++) begin
      pulse();
      for (int i = 0; i < 12; i++) begin buf_data = W'(f * 16 + i); tick(); end
    end
    chk("rr_frames", 64'(frame_count), 64'd5);

    // Backpressure: granted ready toggles every cycle.
    req = 2'b01;
    pulse();
    for (int i = 0; i < 22; i++) begin
      m_ready = (i % 2 == 0) ? 2'b01 : 2'b00;
      buf_data = W'(200 + i);
      tick();
    end
    chk("bp_frames", 64'(frame_count), 64'd6);

    // Overrun while idle.
    req = 2'b00; m_ready = 2'b11;
    for (int p = 0; p < 3; p++) begin pulse(); tick(); end
    chk("idle_drops", 64'(drop_count), 64'd2);
    req = 2'b10;
    for (int i = 0; i < 14; i++) tick();
    chk("idle_then_frame", 64'(frame_count), 64'd7);

    // Abort mid-stream at beat 3.
    req = 2'b11;
    pulse();
    repeat (4) tick();
    pulse();
    for (int i = 0; i < 14; i++) tick();
    chk("abort_drops", 64'(drop_count), 64'd3);

    // Reset mid-stream.
    req = 2'b01;
    pulse();
    repeat (5) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    repeat (3) tick();

`ifdef DRAIN_TIMEOUT_EN
    // Hung consumer: watchdog aborts.
    req = 2'b01; m_ready = 2'b00; buf_valid = 1'b1;
    pulse();
    repeat (40) tick();
    req = 2'b00; m_ready = 2'b11;
    repeat (4) tick();
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end

    // Drop counter saturation.
    buf_valid = 1'b0; req = 2'b00;
    for (int p = 0; p < 300; p++) begin pulse(); tick(); end
    chk("drop_saturate", 64'(drop_count), 64'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pingpong_drain_arbiter.md
Name: pingpong_drain_arbiter

Overview:
- Sequences readout of completed frames from the ping-pong sample buffer and shares its read port between two consumers, e.g. a DSP engine and a UART debug dumper.
- Each frame is granted atomically to one requester, chosen round-robin, and streamed sample by sample with a last marker.
- Detects frames lost to buffer swaps (overrun) and counts them.
- Sits between the buffer's read handshake and the consumers.

Parameters:
- WIDTH, 36, sample width in bits.
- DEPTH, 256, samples per frame (power of two, ≥4).
- ADDR_WIDTH, $clog2(DEPTH), sizes the beat counter (ADDR_WIDTH+1 bits).
- TIMEOUT_CYCLES, 1024, stall watchdog limit; used only with DRAIN_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- buf_ready_i  in  1  one-cycle pulse from the buffer: a new frame has swapped into the read bank
- buf_data_i  in  WIDTH  signed sample from the buffer read port
- buf_valid_i  in  1  buffer read valid
- buf_rd_ready_o  out  1  read ready to the buffer
- req_i  in  2  per-consumer frame request (level)
- gnt_o  out  2  one-hot grant, held for the whole frame
- m_data_o  out  WIDTH  sample to the granted consumer
- m_valid_o  out  1  sample valid
- m_last_o  out  1  marks beat DEPTH-1
- m_ready_i  in  2  per-consumer ready
- busy_o  out  1  high in STREAM
- frame_drop_o  out  1  one-cycle pulse per dropped or aborted frame
- frame_count_o  out  16  completed frames, wraps
- drop_count_o  out  8  dropped/aborted frames, saturates at 255

Behaviour:
- Reset values:
  - State IDLE; all outputs 0, including gnt_o=2'b00.
  - pending_q=0, rr_q=0, beat_q=0, frame_count_o=0, drop_count_o=0.
- pending_q:
  - Set the cycle after buf_ready_i is seen.
  - Cleared when a grant is issued.
- States:
  - IDLE: if pending_q and |req_i, go to STREAM next cycle and register gnt_o.
    - Both requesting: grant index rr_q.
    - One requesting: grant that one.
    - So gnt_o rises 2 cycles after a buf_ready_i pulse when a request is already present.
  - STREAM, with g = granted index:
    - m_data_o = buf_data_i; m_valid_o = buf_valid_i; buf_rd_ready_o = m_ready_i[g]. All combinational, zero latency.
    - A beat is accepted when buf_valid_i && m_ready_i[g]; beat_q then increments.
    - m_last_o = m_valid_o && beat_q==DEPTH-1.
    - When the last beat is accepted, go to DONE.
    - m_ready_i of the non-granted consumer is ignored.
    - Deassertion of req_i during STREAM is ignored; the frame is atomic.
  - DONE (1 cycle):
    - gnt_o=0, beat_q=0, frame_count_o+1, rr_q = ~g.
    - Go to IDLE.
  - ABORT (1 cycle):
    - gnt_o=0, m_valid_o=0, beat_q=0, rr_q = ~g.
    - frame_drop_o=1, drop_count_o+1 (saturating).
    - pending_q=1 (the new frame is pending).
    - Go to IDLE.
- Outside STREAM, m_valid_o, m_last_o and buf_rd_ready_o are 0.
- Overrun cases:
  - buf_ready_i while pending_q=1 and not STREAM: frame_drop_o pulses next cycle, drop_count_o+1, pending_q stays 1. The newest frame replaces the old.
  - buf_ready_i during STREAM: the current frame is corrupted because the buffer resets its read pointer on swap. Go to ABORT next cycle; no m_last_o is issued.
  - buf_ready_i in the same cycle as the last-beat acceptance: the frame completes (DONE) and pending_q is set. No drop.
- Counters:
  - drop_count_o holds at 255.
  - frame_count_o wraps 0xFFFF→0.
- rst_i asserted mid-stream: everything returns to reset values next cycle. No drop is counted.

Optional Feature:
- Macro: DRAIN_TIMEOUT_EN.
- Defined:
  - A stall counter runs in STREAM. It clears on every accepted beat and increments otherwise.
  - On reaching TIMEOUT_CYCLES, go to ABORT (same effects as overrun abort).
  - Purpose: a hung consumer cannot block the buffer.
- Not defined: no counter; STREAM waits indefinitely.

Test Plan:
- Basic drain (DEPTH=8): req_i=01, pulse buf_ready_i, buf_valid_i=1, m_ready_i=01 → gnt_o=01 two cycles after the pulse; 8 beats; m_last_o only on beat 7; frame_count_o=1; gnt_o=0 after DONE.
- Round-robin: req_i=11 held, 4 frames → grants 01, 10, 01, 10; frame_count_o=4.
- Backpressure: m_ready_i[g] toggling 1/0 each cycle → buf_rd_ready_o mirrors it; exactly 8 beats in 16 cycles; data order preserved.
- Overrun while idle: req_i=00, 3 buf_ready_i pulses → 2 frame_drop_o pulses, drop_count_o=2; raising req_i=10 streams one frame.
- Abort mid-stream: buf_ready_i at beat 3 → ABORT; frame_drop_o=1; no m_last_o; drop_count_o+1; next frame granted to the other requester.
- Saturation/timeout: 300 idle overruns → drop_count_o=255. With DRAIN_TIMEOUT_EN and TIMEOUT_CYCLES=16, m_ready_i=0 in STREAM → ABORT after 16 cycles.
